pc_fetch_sequencer: RTL and testbench

Fetch-stage controller for the 16-bit pipelined CPU. It owns the program counter and sequences instruction-memory requests over a hold-until-ready handshake. It applies branch redirects from the branch-resolution logic (the PC_control target) and decode stalls from the hazard unit, and stops fetching on HLT. It drives the IF/ID boundary (valid, PC, PC+2, instruction) and holds at most one extra fetched instruction in an internal skid buffer.

---
 rtl/pc_fetch_sequencer_if.sv | 24 ++
 rtl/pc_fetch_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request channel: hold-until-ready handshake.
// The fetch sequencer is the master; the instruction memory is the slave.
interface pc_fetch_sequencer_if #(
   parameter int WIDTH = 16
) ();
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_ready;
   logic [WIDTH-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues instruction-memory requests,
// applies branch redirects and decode stalls, stops on HLT, and drives the
// IF/ID boundary with a one-entry skid buffer behind it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | request at pc outstanding; completion goes to IF/ID or skid
// BUF     | skid holds one fetched instruction; no request until it drains
// SQUASH  | stale request still waiting; its data is dropped, then pc<=pend_pc
// HALT    | HLT fetched; no requests, IF/ID drains; left only by redirect/rst
module pc_fetch_sequencer #(
   parameter int               WIDTH      = 16,
   parameter logic [WIDTH-1:0] RESET_PC   = '0,
   parameter logic [3:0]       HLT_OPCODE = 4'hF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [WIDTH-1:0]      redirect_pc,
   pc_fetch_sequencer_if.master  imem,
   output logic                  if_valid,
   output logic [WIDTH-1:0]      if_pc,
   output logic [WIDTH-1:0]      if_pc_plus2,
   output logic [WIDTH-1:0]      if_instr,
   output logic                  halted
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_BUF    = 2'd1,
      S_SQUASH = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(2);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic [WIDTH-1:0] bpc_q, bpc_d;
   logic [WIDTH-1:0] binstr_q, binstr_d;
   logic             if_valid_q, if_valid_d;
   logic [WIDTH-1:0] if_pc_q, if_pc_d;
   logic [WIDTH-1:0] if_pc_plus2_q, if_pc_plus2_d;
   logic [WIDTH-1:0] if_instr_q, if_instr_d;
   logic             halted_q, halted_d;

   logic             req_int;
   logic             done;
   logic             accept;
   logic             rdata_hlt;
   logic             buf_hlt;
   logic [WIDTH-1:0] redir_tgt;

   // Request is a pure decode of the state; held low while rst is asserted
   // so nothing goes out in the reset cycle. The address is pc in both
   // requesting states because pc is frozen while a squashed request waits.
   assign req_int        = (state_q == S_FETCH) || (state_q == S_SQUASH);
   assign imem.imem_req  = req_int && !rst;
   assign imem.imem_addr = pc_q;

   // Handshake decode and output-acceptance conditions.
   always_comb begin
      done      = req_int && imem.imem_ready;
      accept    = !stall || !if_valid_q;
      rdata_hlt = (imem.imem_rdata[WIDTH-1:WIDTH-4] == HLT_OPCODE);
      buf_hlt   = (binstr_q[WIDTH-1:WIDTH-4] == HLT_OPCODE);
      redir_tgt = redirect_pc & ~WIDTH'(1);
   end

   // Next-state computation for the FSM, PC, skid buffer and IF/ID register.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_pc_d     = pend_pc_q;
      bpc_d         = bpc_q;
      binstr_d      = binstr_q;
      if_valid_d    = if_valid_q;
      if_pc_d       = if_pc_q;
      if_pc_plus2_d = if_pc_plus2_q;
      if_instr_d    = if_instr_q;

      if (redirect_valid) begin
         // A redirect kills IF/ID and the skid even under stall. An
         // outstanding request cannot be aborted, so it is ridden out in
         // SQUASH; a same-cycle completion is simply dropped.
         if_valid_d = 1'b0;
         if (req_int && !imem.imem_ready) begin
            pend_pc_d = redir_tgt;
            state_d   = S_SQUASH;
         end else begin
            pc_d    = redir_tgt;
            state_d = S_FETCH;
         end
      end else begin
         // Without a new load, an unstalled IF/ID empties.
         if (!stall) begin
            if_valid_d = 1'b0;
         end

         case (state_q)
            S_FETCH: begin
               if (done) begin
                  pc_d = pc_q + PC_STEP;
                  if (accept) begin
                     if_valid_d    = 1'b1;
                     if_pc_d       = pc_q;
                     if_pc_plus2_d = pc_q + PC_STEP;
                     if_instr_d    = imem.imem_rdata;
                     state_d       = rdata_hlt ? S_HALT : S_FETCH;
                  end else begin
                     // IF/ID is full and stalled: park the word. A parked
                     // HLT is resolved to HALT when the buffer drains.
                     bpc_d    = pc_q;
                     binstr_d = imem.imem_rdata;
                     state_d  = S_BUF;
                  end
               end
            end

            S_BUF: begin
               if (!stall) begin
                  if_valid_d    = 1'b1;
                  if_pc_d       = bpc_q;
                  if_pc_plus2_d = bpc_q + PC_STEP;
                  if_instr_d    = binstr_q;
                  state_d       = buf_hlt ? S_HALT : S_FETCH;
               end
            end

            S_SQUASH: begin
               if (done) begin
                  pc_d    = pend_pc_q;
                  state_d = S_FETCH;
               end
            end

            S_HALT: begin
               state_d = S_HALT;
            end

            default: begin
               state_d = S_FETCH;
            end
         endcase
      end

      halted_d = (state_d == S_HALT);
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_FETCH;
         pc_q          <= RESET_PC;
         pend_pc_q     <= '0;
         bpc_q         <= '0;
         binstr_q      <= '0;
         if_valid_q    <= 1'b0;
         if_pc_q       <= '0;
         if_pc_plus2_q <= '0;
         if_instr_q    <= '0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_pc_q     <= pend_pc_d;
         bpc_q         <= bpc_d;
         binstr_q      <= binstr_d;
         if_valid_q    <= if_valid_d;
         if_pc_q       <= if_pc_d;
         if_pc_plus2_q <= if_pc_plus2_d;
         if_instr_q    <= if_instr_d;
         halted_q      <= halted_d;
      end
   end

   assign if_valid    = if_valid_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus2 = if_pc_plus2_q;
   assign if_instr    = if_instr_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios followed by randomized
// traffic, all compared each cycle against a transaction-level model.
module tb_pc_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        if_valid;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus2;
   logic [15:0] if_instr;
   logic        halted;

   pc_fetch_sequencer_if #(.WIDTH(16)) imem_if ();

   pc_fetch_sequencer #(
      .WIDTH      (16),
      .RESET_PC   (16'h0000),
      .HLT_OPCODE (4'hF)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (imem_if),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pc_plus2    (if_pc_plus2),
      .if_instr       (if_instr),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   // memory environment
   logic [15:0] hlt_addr  = 16'h0001;
   logic [15:0] slow_addr = 16'h0001;
   int          slow_wait = 0;
   bit          rand_wait = 0;
   bit          mem_busy  = 0;
   int          mem_cnt   = 0;
   bit          cur_req;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == hlt_addr) return 16'hF000;
      return 16'h1000 + {4'h0, a[12:1]};
   endfunction

   // reference model: next fetch address, optional squash target,
   // a queue standing in for the skid, and the IF/ID contents
   logic [15:0] m_fetch_pc = 16'h0000;
   logic [15:0] m_sq_tgt   = 16'h0000;
   bit          m_sq       = 0;
   bit          m_halt     = 0;
   logic [31:0] m_skid[$];
   bit          m_v        = 0;
   logic [15:0] m_pc       = 16'h0000;
   logic [15:0] m_instr    = 16'h0000;
   bit          m_zero     = 1;

   function automatic bit m_req();
      return m_sq || (!m_halt && m_skid.size() == 0);
   endfunction

   function automatic void m_load(input logic [31:0] e);
      m_v     = 1;
      m_pc    = e[31:16];
      m_instr = e[15:0];
      m_zero  = 0;
   endfunction

   function automatic void m_step(input bit r, input bit s, input bit rv,
                                  input logic [15:0] rpc, input bit rdy,
                                  input logic [15:0] rdt);
      bit          req;
      bit          got;
      logic [31:0] g;
      req = !r && m_req();
      got = 0;
      g   = '0;
      if (r) begin
         m_fetch_pc = 16'h0000;
         m_sq       = 0;
         m_halt     = 0;
         m_skid.delete();
         m_v        = 0;
         m_pc       = 16'h0000;
         m_instr    = 16'h0000;
         m_zero     = 1;
      end else if (rv) begin
         if (req && !rdy) begin
            m_sq     = 1;
            m_sq_tgt = rpc & 16'hFFFE;
         end else begin
            m_sq       = 0;
            m_fetch_pc = rpc & 16'hFFFE;
         end
         m_halt = 0;
         m_skid.delete();
         m_v = 0;
      end else begin
         if (req && rdy) begin
            if (m_sq) begin
               m_sq       = 0;
               m_fetch_pc = m_sq_tgt;
            end else begin
               got        = 1;
               g          = {m_fetch_pc, rdt};
               m_fetch_pc = m_fetch_pc + 16'd2;
               if (rdt[15:12] == 4'hF) m_halt = 1;
            end
         end
         if (!s) begin
            if (m_skid.size() != 0) m_load(m_skid.pop_front());
            else if (got) m_load(g);
            else m_v = 0;
         end else if (got) begin
            if (!m_v) m_load(g);
            else m_skid.push_back(g);
         end
      end
   endfunction

   // One clock: drive inputs on the falling edge, check, answer memory,
   // then advance the model and memory on the rising edge.
   task automatic cycle(input bit r, input bit s, input bit rv, input logic [15:0] rpc);
      bit          exp_req;
      logic [15:0] exp_p2;
      @(negedge clk);
      rst            = r;
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      exp_req = !r && m_req();
      check("if_valid", {31'd0, if_valid}, {31'd0, m_v});
      check("halted", {31'd0, halted}, {31'd0, (m_halt && m_skid.size() == 0 && !m_sq)});
      check("imem_req", {31'd0, imem_if.imem_req}, {31'd0, exp_req});
      if (exp_req) check("imem_addr", {16'd0, imem_if.imem_addr}, {16'd0, m_fetch_pc});
      if (m_v || m_zero) begin
         exp_p2 = m_zero ? 16'h0000 : m_pc + 16'd2;
         check("if_pc", {16'd0, if_pc}, {16'd0, m_pc});
         check("if_pc_plus2", {16'd0, if_pc_plus2}, {16'd0, exp_p2});
         check("if_instr", {16'd0, if_instr}, {16'd0, m_instr});
      end
      cur_req = imem_if.imem_req;
      if (cur_req) begin
         if (!mem_busy) begin
            mem_busy = 1;
            if (imem_if.imem_addr == slow_addr) mem_cnt = slow_wait;
            else if (rand_wait) mem_cnt = $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 3));
            else mem_cnt = 0;
         end
         imem_if.imem_ready = (mem_cnt == 0);
         imem_if.imem_rdata = mem_word(imem_if.imem_addr);
      end else begin
         imem_if.imem_ready = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
         imem_if.imem_rdata = 16'($urandom);
      end
      @(posedge clk);
      m_step(r, s, rv, rpc, imem_if.imem_ready, imem_if.imem_rdata);
      if (r) mem_busy = 0;
      else if (cur_req && imem_if.imem_ready) mem_busy = 0;
      else if (cur_req) mem_cnt--;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 16'h0000);
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 16'h0000);
   endtask

   initial begin
      rst                = 1'b1;
      stall              = 1'b0;
      redirect_valid     = 1'b0;
      redirect_pc        = 16'h0000;
      imem_if.imem_ready = 1'b0;
      imem_if.imem_rdata = 16'h0000;

      // zero-wait streaming
      do_reset();
      do_reset();
      run(6);

      // two wait states on address 4
      slow_addr = 16'h0004; slow_wait = 2;
      do_reset();
      run(8);

      // stall while IF/ID holds pc 2 and pc 4 completes into the skid
      slow_addr = 16'h0001; slow_wait = 0;
      do_reset();
      run(2);
      cycle(0, 1, 0, 16'h0000);
      cycle(0, 1, 0, 16'h0000);
      cycle(0, 1, 0, 16'h0000);
      run(4);

      // redirect to an odd target while address 8 is waiting
      slow_addr = 16'h0008; slow_wait = 3;
      do_reset();
      run(5);
      cycle(0, 0, 1, 16'h0041);
      run(6);

      // HLT at 6, then redirect out of halt
      slow_addr = 16'h0001; slow_wait = 0; hlt_addr = 16'h0006;
      do_reset();
      run(8);
      cycle(0, 0, 1, 16'h0020);
      run(4);

      // HLT parked in the skid under stall
      do_reset();
      run(3);
      cycle(0, 1, 0, 16'h0000);
      cycle(0, 1, 0, 16'h0000);
      run(4);
      hlt_addr = 16'h0001;

      // redirect with stall and a completing fetch in the same cycle
      do_reset();
      run(3);
      cycle(0, 1, 1, 16'h0010);
      run(3);

      // rst during a memory wait
      slow_addr = 16'h0004; slow_wait = 3;
      do_reset();
      run(3);
      do_reset();
      slow_addr = 16'h0001; slow_wait = 0;
      run(3);

      // PC wrap past 16'hFFFE
      cycle(0, 0, 1, 16'hFFFB);
      run(5);

      // randomized traffic
      rand_wait = 1;
      hlt_addr  = 16'h0010;
      for (int i = 0; i < 3000; i++) begin
         bit          r_r, r_s, r_rv;
         logic [15:0] r_pc;
         r_r  = ($urandom_range(0, 99) < 1);
         r_s  = ($urandom_range(0, 99) < 30);
         r_rv = ($urandom_range(0, 99) < 6);
         r_pc = ($urandom_range(0, 9) == 0) ? 16'hFFF0 | 16'($urandom_range(0, 15))
                                              : 16'($urandom_range(0, 63));
         cycle(r_r, r_s, r_rv, r_pc);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
